// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch-queue definitions: default geometry, entry layout and a lane-mask popcount.
package fetch_inst_queue_pkg;

    localparam int DEF_FETCH_WIDTH = 4;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_INST_W      = 64;
    localparam int DEF_PC_W        = 32;
    localparam int DEF_PTR_W       = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W       = DEF_PTR_W + 1;
    localparam int MAX_LANES       = 8;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INST_W-1:0] inst;
    } fetchEntry_t;

    // Narrower masks are zero-extended by the caller.
    function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] mask);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {3'b000, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_inst_queue_compactor.sv
// Combinational lane compactor: each valid lane's write offset from the tail is the
// number of valid lanes below it; nEnq is the total valid-lane count.
module fetch_lane_compactor
    import fetch_inst_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int LANE_W      = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]             instValid,
    output logic [FETCH_WIDTH-1:0][LANE_W-1:0] laneOffset,
    output logic [LANE_W-1:0]                  nEnq
);

    always_comb begin
        logic [LANE_W-1:0] acc;
        acc        = '0;
        laneOffset = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            laneOffset[k] = acc;
            acc           = acc + LANE_W'(instValid[k]);
        end
    end

    assign nEnq = LANE_W'(popcount(MAX_LANES'(instValid)));

endmodule

// File: rtl/fetch_inst_queue.sv
// Decoupling instruction queue between the I-cache stage and decode: compacts sparse
// fetch bundles into a circular buffer and presents up to FETCH_WIDTH oldest entries.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int INST_W      = DEF_INST_W,
    parameter int PC_W        = DEF_PC_W,
    parameter int PTR_W       = $clog2(DEPTH),
    parameter int CNT_W       = PTR_W + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [FETCH_WIDTH-1:0][PC_W-1:0]   instPC_i,
    input  logic [FETCH_WIDTH-1:0][INST_W-1:0] inst_i,
    input  logic [FETCH_WIDTH-1:0]             instValid_i,
    input  logic                               flush_i,
    input  logic                               deqReady_i,
    output logic [FETCH_WIDTH-1:0][PC_W-1:0]   instPC_o,
    output logic [FETCH_WIDTH-1:0][INST_W-1:0] inst_o,
    output logic [FETCH_WIDTH-1:0]             instValid_o,
    output logic                               stallFetch_o,
    output logic [CNT_W-1:0]                   occupancy_o
);

    localparam int LANE_W = $clog2(FETCH_WIDTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] headPtr, tailPtr;
    logic [CNT_W-1:0] count;

    logic [FETCH_WIDTH-1:0][LANE_W-1:0] laneOffset;
    logic [LANE_W-1:0]                  nEnq, nEnqEff;
    logic [CNT_W-1:0]                   nAvail, nDeq;
    logic                               enqEn, deqEn;

    fetch_lane_compactor #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .LANE_W      (LANE_W)
    ) uCompactor (
        .instValid  (instValid_i),
        .laneOffset (laneOffset),
        .nEnq       (nEnq)
    );

    // Stall looks only at the registered count, so a same-cycle dequeue never opens room.
    assign stallFetch_o = count > CNT_W'(DEPTH - FETCH_WIDTH);
    assign occupancy_o  = count;

    assign enqEn   = (|instValid_i) & ~stallFetch_o & ~flush_i;
    assign deqEn   = deqReady_i & ~flush_i;
    assign nAvail  = (count < CNT_W'(FETCH_WIDTH)) ? count : CNT_W'(FETCH_WIDTH);
    assign nEnqEff = enqEn ? nEnq : '0;
    assign nDeq    = deqEn ? nAvail : '0;

    always_comb begin
        instPC_o    = '0;
        inst_o      = '0;
        instValid_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            instPC_o[k]    = mem[headPtr + PTR_W'(k)].pc;
            inst_o[k]      = mem[headPtr + PTR_W'(k)].inst;
            instValid_o[k] = (CNT_W'(k) < nAvail) & ~flush_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush_i) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headPtr + PTR_W'(nDeq);
            tailPtr <= tailPtr + PTR_W'(nEnqEff);
            count   <= count + CNT_W'(nEnqEff) - nDeq;
        end
    end

    // Storage carries no reset; validity is tracked entirely by head/count.
    always_ff @(posedge clk) begin
        if (enqEn) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (instValid_i[k]) begin
                    mem[tailPtr + PTR_W'(laneOffset[k])] <= '{pc: instPC_i[k], inst: inst_i[k]};
                end
            end
        end
    end

    countBounded: assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(DEPTH));
    countNoUnderflow: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, count} + (CNT_W + 1)'(nEnqEff)) >= (CNT_W + 1)'(nDeq));
    validContiguous: assert property (@(posedge clk) disable iff (reset)
        (instValid_o & (instValid_o + FETCH_WIDTH'(1))) == '0);

endmodule
